// File: rtl/pipeline_join.sv
// N-channel join: each channel buffers into its own FIFO, and one joined beat
// pops the head of every FIFO at once when all of them hold data.
module pipeline_join #(
  parameter int N     = 2,
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        i_valid,
  output logic [N-1:0]        i_ready,
  input  logic [N-1:0][W-1:0] i_data,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [N*W-1:0]      o_data,
  output logic [N-1:0][LW-1:0] o_level
);

  localparam int PW = $clog2(DEPTH);

  logic [N-1:0] nonempty_s;
  logic         pop_s;

  // Join handshake depends only on occupancy registers, never on o_ready or i_valid.
  always_comb begin
    o_valid = &nonempty_s;
    pop_s   = o_valid & o_ready;
  end

  for (genvar g = 0; g < N; g++) begin : g_chan
    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] count_r;
    logic          push_s;

    assign i_ready[g]         = (count_r < LW'(DEPTH));
    assign nonempty_s[g]      = (count_r != {LW{1'b0}});
    assign push_s             = i_valid[g] & i_ready[g];
    assign o_level[g]         = count_r;
    assign o_data[g*W +: W]   = mem_r[rd_ptr_r];

    // Storage array carries no reset; only pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= i_data[g];
      end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
        count_r  <= {LW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + LW'(1);
          2'b01:   count_r <= count_r - LW'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule

// File: doc/pipeline_join.md
PIPELINE_JOIN -- requirements
Module: pipeline_join

Interface
REQ-001 Parameter N, default 2, number of input channels (N >= 1).
REQ-002 Parameter W, default 32, data width per channel (W >= 1).
REQ-003 Parameter DEPTH, default 2, entries per channel buffer (power of two, DEPTH >= 2).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 i_valid  input  N  per-channel source valid, one bit per channel.
REQ-007 i_ready  output  N  per-channel sink ready, one bit per channel.
REQ-008 i_data  input  N x W  per-channel payload; channel i's payload is element i.
REQ-009 o_valid  output  1  joined beat available.
REQ-010 o_ready  input  1  downstream accepts joined beat.
REQ-011 o_data  output  N*W  joined payload; channel i at bits [i*W +: W].
REQ-012 o_level  output  N x $clog2(DEPTH+1)  per-channel buffer occupancy.

Function
REQ-013 Each channel shall own an independent FIFO of DEPTH entries with a write pointer, a read pointer and an occupancy count.
REQ-014 Channel i push: i_valid[i] & i_ready[i] at a rising edge writes i_data[i] into FIFO i.
REQ-015 i_ready[i] shall be 1 exactly when occupancy[i] < DEPTH, decoded from registers only, with no combinational path from o_ready or any i_valid.
REQ-016 o_valid shall be 1 exactly when every channel's occupancy is >= 1, decoded from registers only.
REQ-017 o_data shall present the head entry of every FIFO whenever o_valid is 1; value is don't-care when o_valid is 0.
REQ-018 Pop: o_valid & o_ready at a rising edge removes the head entry of all N FIFOs simultaneously; no FIFO is ever popped alone.
REQ-019 Latency: a word pushed into an empty FIFO shall be visible at the FIFO head on the cycle after the push; minimum input-to-output latency is 1 cycle.
REQ-020 Throughput: with all i_valid and o_ready held at 1, one joined beat shall be accepted and one produced every cycle after the first.
REQ-021 Simultaneous push and pop on the same channel in one cycle shall leave that channel's occupancy unchanged and preserve FIFO order.
REQ-022 Full channel: i_ready[i] is 0. A pop in that cycle frees one slot, but the push is not taken until the next cycle (no full-bypass).
REQ-023 Pointers shall wrap from DEPTH-1 to 0 with no loss or duplication of entries.
REQ-024 Channels shall be skew-tolerant: a channel may run up to DEPTH beats ahead of the slowest channel before stalling.
REQ-025 o_level[i] shall equal occupancy[i] and shall update on the same edge as the push or pop that changes it.
REQ-026 o_valid shall not drop without a pop, and o_data shall not change while o_valid=1 and o_ready=0.

Reset
REQ-027 With rst=1 at a rising edge, all pointers and occupancies shall be cleared to 0, regardless of any push or pop in that cycle.
REQ-028 Outputs on the cycle after reset: o_valid=0, o_level=0 for all channels, i_ready=all ones.
REQ-029 Reset asserted mid-stream shall discard all buffered data; no beat shall be produced from pre-reset content.
REQ-030 Memory array contents need no reset.

Verification (N=2, W=8, DEPTH=2)
REQ-031 Aligned stream: both channels push 0x01..0x04 on consecutive cycles with o_ready=1 -> o_data = {0x01,0x01}..{0x04,0x04}, one beat per cycle, first beat 1 cycle after first push.
REQ-032 Skew: ch0 pushes 0xA0,0xA1 while ch1 is idle; then ch1 pushes 0xB0 -> o_valid=0 until the cycle after the 0xB0 push; first beat = {0xB0,0xA0}; o_level[0] is 2 before the pop.
REQ-033 Backpressure: o_ready=0, both channels push 3 words -> i_ready drops after 2 pushes, third word held by source; after o_ready=1, output order is 1,2,3 with no loss.
REQ-034 Full plus pop: ch0 full, pop occurs -> i_ready[0] stays 0 in the pop cycle and is 1 on the next cycle.
REQ-035 Wrap: 10 beats streamed with random stalls on o_ready and i_valid -> scoreboard matches per-channel order exactly, pointers wrap at least 4 times.
REQ-036 Mid-stream reset: rst=1 for 1 cycle with both FIFOs at level 1 -> next cycle o_valid=0, o_level=0, i_ready=2'b11; no stale beat appears afterward.
